// File: rtl/uart_beacon_pkg.sv
// rtl/uart_beacon_pkg.sv - shared constants for the UART message beacon
//
// Contents:
//   DEFAULT_CLKS_PER_BIT : bit period in clock cycles (115200 baud at 50 MHz)
//   DATA_BITS            : payload bits per UART frame
//   START_BIT / STOP_BIT / IDLE_LEVEL : serial line levels
//   ST_* / tx_state_t    : serializer state encoding
//   even_parity()        : parity bit that makes the total count of ones even
//
// Configuration macro: UART_BEACON_PARITY_EN (the ST_PARITY state is reachable only
// when it is defined).

package uart_beacon_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef logic [2:0] tx_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART byte serializer with back-to-back load handshake
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   take data and start a frame (honoured only while ready=1)
//   data   in   8-bit byte to send
//   ready  out  core is idle, or is in the final cycle of a stop bit
//   busy   out  a frame is on the line (start bit through stop bit)
//   tx     out  serial line, idle high
//
// Configuration macro: UART_BEACON_PARITY_EN adds an even-parity bit after the data bits.

import uart_beacon_pkg::*;

module uart_tx_core #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    logic [CW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

`ifdef UART_BEACON_PARITY_EN
    logic parity_q;
`endif

    assign bit_end = (timer == BIT_LAST);

    // Ready in the last stop-bit cycle lets the next byte's start bit follow
    // with no idle gap.
    assign ready = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= IDLE_LEVEL;
`ifdef UART_BEACON_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE || bit_end) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (load) begin
                        state   <= ST_START;
                        shreg   <= data;
                        bit_idx <= '0;
                        tx      <= START_BIT;
`ifdef UART_BEACON_PARITY_EN
                        parity_q <= even_parity(data);
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_BEACON_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= parity_q;
`else
                            state <= ST_STOP;
                            tx    <= STOP_BIT;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
`ifdef UART_BEACON_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                        tx    <= STOP_BIT;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (load) begin
                            state   <= ST_START;
                            shreg   <= data;
                            bit_idx <= '0;
                            tx      <= START_BIT;
`ifdef UART_BEACON_PARITY_EN
                            parity_q <= even_parity(data);
`endif
                        end else begin
                            state <= ST_IDLE;
                            tx    <= IDLE_LEVEL;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_msg_beacon.sv
// rtl/uart_msg_beacon.sv - sends a stored message over UART on trigger or periodically
//
// Ports:
//   clk_50M  in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears message storage too)
//   wr_en    in   message byte write strobe
//   wr_addr  in   [AW-1:0] message byte index
//   wr_data  in   [7:0] message byte value
//   msg_len  in   [AW:0] bytes to send, clamped to MSG_DEPTH at acceptance
//   auto_en  in   enables periodic transmission every PERIOD_CYCLES
//   trig     in   single-cycle manual start request
//   busy     out  high from first start bit through last stop bit
//   done     out  one-cycle pulse after the last stop bit
//   tx       out  UART serial line, idle high
//
// Configuration macro: UART_BEACON_PARITY_EN (passed through to uart_tx_core).

import uart_beacon_pkg::*;

module uart_msg_beacon #(
    parameter  int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter  int MSG_DEPTH     = 16,
    parameter  int PERIOD_CYCLES = 50_000_000,
    localparam int AW            = $clog2(MSG_DEPTH)
) (
    input  logic          clk_50M,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   msg_len,
    input  logic          auto_en,
    input  logic          trig,
    output logic          busy,
    output logic          done,
    output logic          tx
);

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [AW:0]   LEN_MAX     = (AW + 1)'(MSG_DEPTH);

    logic [7:0]    mem [MSG_DEPTH];
    logic [PW-1:0] period_cnt;

    logic          active;
    logic [AW:0]   len_q;
    logic [AW:0]   next_idx;

    logic [AW:0]   eff_len;
    logic          start_req;
    logic          accept;
    logic          more;
    logic          finish;
    logic          core_load;
    logic          core_ready;
    logic [AW-1:0] rd_idx;
    logic [7:0]    rd_byte;

    assign eff_len   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    assign start_req = trig || (auto_en && (period_cnt == PERIOD_LAST));

    // Requests outside idle or with zero length are dropped, never queued.
    assign accept    = !active && start_req && (eff_len != '0);
    assign more      = active && core_ready && (next_idx != len_q);
    assign finish    = active && core_ready && (next_idx == len_q);
    assign core_load = accept || more;

    // The byte is fetched at the moment the core takes it, so late writes to
    // unsent bytes are picked up.
    assign rd_idx  = accept ? '0 : next_idx[AW-1:0];
    assign rd_byte = mem[rd_idx];

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (!auto_en || (period_cnt == PERIOD_LAST)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            len_q    <= '0;
            next_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                active   <= 1'b1;
                len_q    <= eff_len;
                next_idx <= (AW + 1)'(1);
            end else if (more) begin
                next_idx <= next_idx + 1'b1;
            end else if (finish) begin
                active <= 1'b0;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_core (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .load  (core_load),
        .data  (rd_byte),
        .ready (core_ready),
        .busy  (busy),
        .tx    (tx)
    );

endmodule

// File: tb/tb_uart_msg_beacon.sv
// tb/tb_uart_msg_beacon.sv - directed self-checking bench for uart_msg_beacon

module tb_uart_msg_beacon;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int PER   = 200;
    localparam int AW    = 4;

`ifdef UART_BEACON_PARITY_EN
    localparam int FL = 11;
    localparam logic [0:21] EXP = 22'b0_00010010_0_1_0_10010110_0_1;
`else
    localparam int FL = 10;
    localparam logic [0:19] EXP = 20'b0_00010010_1_0_10010110_1;
`endif
    localparam int FRAME_CYC = FL * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW:0]   msg_len;
    logic          auto_en;
    logic          trig;
    logic          busy;
    logic          done;
    logic          tx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int dones = 0;
    int frames = 0;
    int starts[$];
    logic [7:0] rx_q[$];
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;

    uart_msg_beacon #(
        .CLKS_PER_BIT  (CPB),
        .MSG_DEPTH     (DEPTH),
        .PERIOD_CYCLES (PER)
    ) dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .msg_len (msg_len),
        .auto_en (auto_en),
        .trig    (trig),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame receiver: locks on a start bit, skips the whole frame, samples
    // data bits mid-bit.
    always @(negedge clk) begin
        if (done === 1'b1) dones++;
        if (rst_n !== 1'b1) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                frames++;
                starts.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB == CPB / 2) && (rx_cnt / CPB >= 1) && (rx_cnt / CPB <= 8))
                rx_byte[rx_cnt / CPB - 1] = tx;
            if (rx_cnt == FRAME_CYC - 1) begin
                rx_busy = 1'b0;
                rx_q.push_back(rx_byte);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_trig(output int t);
        @(negedge clk);
        trig = 1'b1;
        t = cyc;
        @(negedge clk);
        trig = 1'b0;
    endtask

    initial begin
        int t0, a, f0, d0, done_cyc;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; auto_en = 1'b0; trig = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);

        // Two-byte message, bit-exact timing
        write_byte(4'd0, 8'h48);
        write_byte(4'd1, 8'h69);
        msg_len = 5'd2;
        rx_q.delete();
        pulse_trig(t0);
        for (int k = 0; k < 2 * FRAME_CYC; k++) begin
            check("frame_tx", tx, EXP[k / CPB]);
            check("frame_busy", busy, 1);
            check("frame_done", done, 0);
            @(negedge clk);
        end
        check("done_cycle", cyc, t0 + 2 * FRAME_CYC + 1);
        check("done_pulse", done, 1);
        check("done_busy_low", busy, 0);
        check("done_tx_idle", tx, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("rx_byte0", rx_q[0], 8'h48);
            check("rx_byte1", rx_q[1], 8'h69);
        end

        // Trigger while busy is dropped
        f0 = frames; d0 = dones;
        pulse_trig(t0);
        repeat (10) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (2 * FRAME_CYC + 10) @(negedge clk);
        check("busy_trig_frames", frames - f0, 2);
        check("busy_trig_dones", dones - d0, 1);

        // Zero-length message is a no-op
        msg_len = 5'd0;
        f0 = frames; d0 = dones;
        pulse_trig(t0);
        check("len0_busy", busy, 0);
        check("len0_tx", tx, 1);
        repeat (60) @(negedge clk);
        check("len0_frames", frames - f0, 0);
        check("len0_dones", dones - d0, 0);

        // Periodic repeat
        msg_len = 5'd1;
        starts.delete();
        d0 = dones;
        @(negedge clk);
        auto_en = 1'b1;
        a = cyc;
        repeat (650) @(negedge clk);
        auto_en = 1'b0;
        check("auto_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("auto_first", starts[0], a + PER);
            check("auto_gap1", starts[1] - starts[0], PER);
            check("auto_gap2", starts[2] - starts[1], PER);
        end
        check("auto_dones", dones - d0, 3);
        repeat (60) @(negedge clk);

        // Asynchronous reset in the middle of a data bit
        pulse_trig(t0);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("post_rst_tx", tx, 1);
        end
        check("post_rst_busy", busy, 0);

        // Storage was cleared by reset: byte 0 now sends 0x00
        pulse_trig(t0);
        for (int k = 0; k < FRAME_CYC; k++) begin
            check("zero_frame_tx", tx, (k / CPB == FL - 1) ? 1 : 0);
            @(negedge clk);
        end
        check("zero_done", done, 1);

        // Over-length message clamps to MSG_DEPTH; late write to an unsent byte
        for (int i = 0; i < DEPTH; i++) write_byte(AW'(i), 8'hA0 + 8'(i));
        msg_len = 5'd20;
        rx_q.delete();
        f0 = frames; d0 = dones;
        pulse_trig(t0);
        write_byte(4'd15, 8'h5A);
        done_cyc = -1;
        for (int k = 0; k < DEPTH * FRAME_CYC + 50; k++) begin
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            @(negedge clk);
        end
        check("clamp_done_cycle", done_cyc, t0 + DEPTH * FRAME_CYC + 1);
        check("clamp_frames", frames - f0, DEPTH);
        check("clamp_dones", dones - d0, 1);
        check("clamp_rx_count", rx_q.size(), DEPTH);
        if (rx_q.size() == DEPTH) begin
            for (int i = 0; i < DEPTH - 1; i++) check("clamp_rx_byte", rx_q[i], 8'hA0 + 8'(i));
            check("late_write_byte", rx_q[DEPTH - 1], 8'h5A);
        end
        check("clamp_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
